// File: rtl/gpio_pin_arbiter.sv
// Round-robin owner arbitration for a shared GPIO pin bank.
// The bank passes through a one-cycle tri-state turnaround between owners; pad inputs get a 2-flop synchronizer.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | bank free, pins tri-stated, arbitrate from rr pointer
// ST_OWN  | one requester owns the bank and drives the pins
// ST_TURN | one-cycle turnaround with pins tri-stated before IDLE
module gpio_pin_arbiter #(
  parameter int GPIO_DATA_WIDTH = 16,
  parameter int NUM_REQ         = 4,
  parameter int MAX_HOLD        = 255
) (
  input  logic                                 pclk,
  input  logic                                 p_reset,
  input  logic [NUM_REQ-1:0]                   req,
  input  logic [NUM_REQ-1:0]                   release_i,
  input  logic [NUM_REQ*GPIO_DATA_WIDTH-1:0]   req_oe_n,
  input  logic [NUM_REQ*GPIO_DATA_WIDTH-1:0]   req_out,
  input  logic [GPIO_DATA_WIDTH-1:0]           gpio_pin_in,
  output logic [NUM_REQ-1:0]                   grant,
  output logic [$clog2(NUM_REQ)-1:0]           owner_id,
  output logic                                 busy,
  output logic [GPIO_DATA_WIDTH-1:0]           n_gpio_pin_oe,
  output logic [GPIO_DATA_WIDTH-1:0]           gpio_pin_out,
  output logic [GPIO_DATA_WIDTH-1:0]           rd_data,
  output logic                                 timeout_err
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int HCW = $clog2(MAX_HOLD + 1);
  localparam int W   = GPIO_DATA_WIDTH;

  typedef enum logic [1:0] {ST_IDLE, ST_OWN, ST_TURN} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDW-1:0]       owner_q, owner_d;
  logic [IDW-1:0]       ptr_q, ptr_d;
  logic [HCW-1:0]       hold_q, hold_d;
  logic                 busy_q, busy_d;
  logic                 tmo_q, tmo_d;
  logic [W-1:0]         oe_n_q, oe_n_d;
  logic [W-1:0]         out_q, out_d;
  logic [W-1:0]         sync1_q, sync2_q;

  logic                 win_found;
  logic [IDW-1:0]       win_idx;
  logic [W-1:0]         own_oe_n, own_out;
  logic                 exit_normal, exit_forced, hold_max, others_req;

  // First requester at or above the rr pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && req[(int'(ptr_q) + k) % NUM_REQ]) begin
        win_found = 1'b1;
        win_idx   = IDW'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end

  assign own_oe_n    = req_oe_n[int'(owner_q)*W +: W];
  assign own_out     = req_out[int'(owner_q)*W +: W];
  assign hold_max    = (hold_q == HCW'(MAX_HOLD));
  assign others_req  = |(req & ~grant_q);
  assign exit_normal = release_i[owner_q] | ~req[owner_q];
  assign exit_forced = hold_max & others_req;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    busy_d  = busy_q;
    tmo_d   = 1'b0;
    oe_n_d  = '1;
    out_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d = ST_OWN;
          grant_d = NUM_REQ'(1) << win_idx;
          owner_d = win_idx;
          busy_d  = 1'b1;
          hold_d  = '0;
        end
      end
      ST_OWN: begin
        if (exit_normal || exit_forced) begin
          state_d = ST_TURN;
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = (owner_q == IDW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
          // a simultaneous voluntary exit masks the revoke
          tmo_d   = ~exit_normal;
        end else begin
          oe_n_d = own_oe_n;
          out_d  = own_out;
          if (!hold_max) hold_d = hold_q + 1'b1;
        end
      end
      ST_TURN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (p_reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
      oe_n_q  <= '1;
      out_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
      oe_n_q  <= oe_n_d;
      out_q   <= out_d;
      sync1_q <= gpio_pin_in;
      sync2_q <= sync1_q;
    end
  end

  assign grant         = grant_q;
  assign owner_id      = owner_q;
  assign busy          = busy_q;
  assign timeout_err   = tmo_q;
  assign n_gpio_pin_oe = oe_n_q;
  assign gpio_pin_out  = out_q;
  assign rd_data       = sync2_q;

endmodule
